pump_pulse_gen: RTL and testbench

Parametrised up/down pump-pulse generator driven by a signed control word. The block integrates |kval| in a phase accumulator and emits one fixed-width pulse on `up` (kval > 0) or `down` (kval < 0) per accumulator wrap. It enforces a minimum gap between pulses and a dead time on direction reversal, and keeps pulse statistics. It sits between the digital loop control (kval source) and the charge-pump drivers `upPort`/`downPort` of the top level.

---
 rtl/pump_pulse_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_pump_pulse_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pump_pulse_gen.sv
// pump_pulse_gen: converts a signed control word into fixed-width up/down
// charge-pump pulses. |kval| is integrated in a phase accumulator, and every
// accumulator wrap queues one pulse request in the direction of kval's sign.
// A small FSM drains the queue. It enforces a one-cycle gap after every pulse
// and inserts dead time before a pulse that reverses direction.
module pump_pulse_gen #(
  parameter int KW    = 40,
  parameter int PW    = 4,
  parameter int DEAD  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [KW-1:0]    kval,
  output logic             up,
  output logic             down,
  output logic             busy,
  output logic [CNT_W-1:0] up_cnt,
  output logic [CNT_W-1:0] down_cnt,
  output logic             ovf
);

  localparam int AW   = KW - 1;
  localparam int TMAX = (PW > DEAD) ? PW : DEAD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] PW_LAST   = TW'(PW - 1);
  localparam logic [TW-1:0] DEAD_LAST = TW'((DEAD > 0) ? DEAD - 1 : 0);
  localparam logic [KW-1:0] KMIN      = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DEADT = 2'd1,
    S_PULSE = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  // Accumulator / request-queue state.
  logic [AW-1:0]    acc_q, acc_d;
  logic [1:0]       pend_q, pend_d;
  logic             req_dir_q, req_dir_d;
  logic             prev_sign_q, prev_sign_d;
  logic             ovf_q, ovf_d;

  // Pulse sequencer state.
  state_t           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             dir_q, dir_d;
  logic             last_dir_q, last_dir_d;
  logic [CNT_W-1:0] up_cnt_q, up_cnt_d;
  logic [CNT_W-1:0] down_cnt_q, down_cnt_d;
  logic             up_q, up_d;
  logic             down_q, down_d;

  // Input decode.
  logic             sign;
  logic             active;
  logic             sign_chg;
  logic [KW-1:0]    neg_kval;
  logic [AW-1:0]    mag;
  logic [AW:0]      sum;
  logic             carry;
  logic             inc;
  logic             take;

  assign sign     = kval[KW-1];
  assign active   = en && (kval != '0);
  // A reversal discards everything queued for the old direction.
  assign sign_chg = active && (sign != prev_sign_q);
  assign neg_kval = -kval;
  assign sum      = {1'b0, acc_q} + {1'b0, mag};
  assign carry    = sum[AW];
  assign inc      = active && !sign_chg && carry;
  // Stale requests are not launched on the cycle they are being discarded.
  assign take     = (pend_q != 2'd0) && !sign_chg &&
                    ((state_q == S_IDLE) || (state_q == S_GAP));

  // Magnitude of kval; the most negative code saturates to the largest positive.
  always_comb begin
    mag = kval[AW-1:0];
    if (kval == KMIN) begin
      mag = {AW{1'b1}};
    end else if (sign) begin
      mag = neg_kval[AW-1:0];
    end
  end

  // Accumulate, queue requests on wrap, and track drops.
  always_comb begin
    acc_d       = acc_q;
    pend_d      = pend_q;
    req_dir_d   = req_dir_q;
    prev_sign_d = prev_sign_q;
    ovf_d       = ovf_q;
    if (active) begin
      prev_sign_d = sign;
      if (sign_chg) begin
        acc_d  = '0;
        pend_d = 2'd0;
      end else begin
        acc_d = sum[AW-1:0];
        if (carry) begin
          req_dir_d = sign;
        end
      end
    end
    if (!sign_chg) begin
      case ({inc, take})
        2'b10: begin
          if (pend_q == 2'd3) begin
            ovf_d = 1'b1;
          end else begin
            pend_d = pend_q + 2'd1;
          end
        end
        2'b01:   pend_d = pend_q - 2'd1;
        default: pend_d = pend_q;
      endcase
    end
  end

  // Accumulator and request-queue registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      pend_q      <= 2'd0;
      req_dir_q   <= 1'b0;
      prev_sign_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      pend_q      <= pend_d;
      req_dir_q   <= req_dir_d;
      prev_sign_q <= prev_sign_d;
      ovf_q       <= ovf_d;
    end
  end

  // Sequencer state register, including the pulse counters and output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      dir_q      <= 1'b0;
      last_dir_q <= 1'b0;
      up_cnt_q   <= '0;
      down_cnt_q <= '0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      up_cnt_q   <= up_cnt_d;
      down_cnt_q <= down_cnt_d;
      up_q       <= up_d;
      down_q     <= down_d;
    end
  end

  // Sequencer next state: launch, dead time, pulse, one-cycle gap.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    up_cnt_d   = up_cnt_q;
    down_cnt_d = down_cnt_q;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (take) begin
          dir_d = req_dir_q;
          tmr_d = '0;
          if ((req_dir_q != last_dir_q) && (DEAD > 0)) begin
            state_d = S_DEADT;
          end else begin
            state_d = S_PULSE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DEADT: begin
        if (tmr_q == DEAD_LAST) begin
          state_d = S_PULSE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_PULSE: begin
        if (tmr_q == PW_LAST) begin
          state_d    = S_GAP;
          tmr_d      = '0;
          last_dir_d = dir_q;
          if (dir_q) begin
            if (down_cnt_q != '1) down_cnt_d = down_cnt_q + CNT_W'(1);
          end else begin
            if (up_cnt_q != '1) up_cnt_d = up_cnt_q + CNT_W'(1);
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so the pump drives come straight from flops.
  always_comb begin
    up_d   = (state_d == S_PULSE) && !dir_d;
    down_d = (state_d == S_PULSE) && dir_d;
  end

  assign up       = up_q;
  assign down     = down_q;
  assign busy     = (state_q != S_IDLE) || (pend_q != 2'd0);
  assign up_cnt   = up_cnt_q;
  assign down_cnt = down_cnt_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_pump_pulse_gen.sv
// Bench for pump_pulse_gen: a request-queue / schedule model predicts every
// pulse (direction and start edge); a monitor matches observed pulses against it.
module tb_pump_pulse_gen;

  localparam int KW    = 8;
  localparam int PW    = 2;
  localparam int DEAD  = 2;
  localparam int CNT_W = 16;
  localparam int MOD   = 1 << (KW - 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic [KW-1:0]    kval = '0;
  logic             up, down, busy, ovf;
  logic [CNT_W-1:0] up_cnt, down_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pump_pulse_gen #(.KW(KW), .PW(PW), .DEAD(DEAD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .kval(kval),
    .up(up), .down(down), .busy(busy),
    .up_cnt(up_cnt), .down_cnt(down_cnt), .ovf(ovf)
  );

  typedef struct packed {
    int   start;
    logic dir;
  } pulse_t;

  pulse_t exp_q[$];      // scoreboard: pulses predicted, not yet seen
  pulse_t m_live[$];     // predicted pulses whose counter update is still ahead
  logic   m_req[$];      // queued requests (direction of each)
  int     edge_n = 0;
  int     m_acc, m_next_free, m_up, m_down;
  logic   m_prev_sign, m_last_dir, m_ovf;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s edge=%0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_next_free = 0; m_up = 0; m_down = 0;
    m_prev_sign = 1'b0; m_last_dir = 1'b0; m_ovf = 1'b0;
    m_req.delete(); m_live.delete(); exp_q.delete();
  endtask

  // One clock edge of the reference: schedule-based, works in absolute edge numbers.
  task automatic model_step(input logic e, input logic [KW-1:0] k);
    int     sk, mag;
    logic   sgn, act, chg;
    pulse_t p;
    edge_n++;
    while (m_live.size() > 0 && m_live[0].start + PW == edge_n) begin
      p = m_live.pop_front();
      if (p.dir) m_down++; else m_up++;
    end
    sk  = k[KW-1] ? int'(k) - (1 << KW) : int'(k);
    sgn = k[KW-1];
    mag = (sk < 0) ? -sk : sk;
    if (mag > MOD - 1) mag = MOD - 1;
    act = e && (sk != 0);
    chg = act && (sgn != m_prev_sign);
    if (!chg && m_req.size() > 0 && edge_n >= m_next_free) begin
      p.dir   = m_req.pop_front();
      p.start = edge_n + ((p.dir != m_last_dir) ? DEAD : 0);
      m_last_dir  = p.dir;
      m_next_free = p.start + PW + 1;
      exp_q.push_back(p);
      m_live.push_back(p);
    end
    if (act) begin
      m_prev_sign = sgn;
      if (chg) begin
        m_acc = 0;
        m_req.delete();
      end else begin
        m_acc += mag;
        if (m_acc >= MOD) begin
          m_acc -= MOD;
          if (m_req.size() < 3) m_req.push_back(sgn);
          else m_ovf = 1'b1;
        end
      end
    end
  endtask

  // Drive inputs for the next edge, then advance the model on that edge.
  task automatic tick(input logic e, input logic [KW-1:0] k);
    en = e;
    kval = k;
    @(posedge clk);
    model_step(e, k);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    check({tag, "_up_cnt"}, up_cnt, m_up);
    check({tag, "_down_cnt"}, down_cnt, m_down);
    check({tag, "_ovf"}, ovf, m_ovf);
  endtask

  // Monitor: pops the scoreboard on each pulse start; checks width, gaps, one-hot.
  logic   mon_hi = 1'b0;
  logic   mon_dir = 1'b0;
  logic   mon_last_dir = 1'b0;
  logic   mon_have_prev = 1'b0;
  int     mon_width = 0;
  int     mon_last_end = 0;
  int     mon_need = 0;
  int     obs_pulses = 0;
  pulse_t mon_p;

  always @(negedge clk) begin : monitor
    if (!reset) begin
      mon_hi = 1'b0;
      mon_width = 0;
      mon_have_prev = 1'b0;
      obs_pulses = 0;
    end else begin
      check("one_hot", up & down, 0);
      if ((up || down) && !mon_hi) begin
        mon_dir = down;
        mon_width = 1;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse_start", edge_n, -1);
        end else begin
          mon_p = exp_q.pop_front();
          check("pulse_start", edge_n, mon_p.start);
          check("pulse_dir", mon_dir, mon_p.dir);
        end
        if (mon_have_prev) begin
          mon_need = (mon_dir != mon_last_dir) ? DEAD + 1 : 1;
          check("gap_ok", (edge_n - mon_last_end) >= mon_need, 1);
        end
      end else if ((up || down) && mon_hi) begin
        mon_width++;
      end else if (!(up || down) && mon_hi) begin
        check("pulse_width", mon_width, PW);
        mon_last_end = edge_n;
        mon_last_dir = mon_dir;
        mon_have_prev = 1'b1;
        obs_pulses++;
      end
      mon_hi = up || down;
    end
  end

  initial begin : stim
    int          guard;
    int          cyc;
    int          hold;
    logic        e;
    logic [KW-1:0] k;

    model_reset();
    #2 reset = 1'b0;
    #10;
    check("rst_up", up, 0);
    check("rst_down", down, 0);
    check("rst_busy", busy, 0);
    check("rst_up_cnt", up_cnt, 0);
    check("rst_down_cnt", down_cnt, 0);
    check("rst_ovf", ovf, 0);
    #1 reset = 1'b1;

    // Steady positive rate: one 2-cycle up pulse every 4 cycles.
    repeat (23) tick(1'b1, 8'h20);
    check("pos_up_cnt_const", up_cnt, 5);
    chk_cnt("pos");

    // Reversal: queue cleared, dead time before the first down pulse.
    repeat (30) tick(1'b1, 8'hE0);
    check("neg_up_cnt_frozen", up_cnt, 5);
    chk_cnt("neg");

    // Most negative word: request rate beyond the pulse rate, queue overflows.
    repeat (20) tick(1'b1, 8'h80);
    check("sat_ovf_const", ovf, 1);
    chk_cnt("sat");
    repeat (12) tick(1'b1, 8'h00);
    check("ovf_sticky", ovf, 1);
    check("drain_busy", busy, 0);
    chk_cnt("zero");
    repeat (12) tick(1'b0, 8'h20);
    chk_cnt("en_off");

    // En drops while a request is queued: the queued pulse still completes.
    guard = 0;
    while (!busy && guard < 100) begin
      tick(1'b1, 8'h20);
      guard++;
    end
    check("busy_wait_timeout", guard < 100, 1);
    repeat (10) tick(1'b0, 8'h20);
    chk_cnt("en_fall");

    // Reset in the second cycle of an up pulse.
    guard = 0;
    while (!up && guard < 100) begin
      tick(1'b1, 8'h20);
      guard++;
    end
    check("up_wait_timeout", guard < 100, 1);
    tick(1'b1, 8'h20);
    check("mid_pulse_up", up, 1);
    #2 reset = 1'b0;
    #1;
    check("async_up", up, 0);
    check("async_up_cnt", up_cnt, 0);
    check("async_down_cnt", down_cnt, 0);
    check("async_ovf", ovf, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    repeat (4) tick(1'b1, 8'h20);
    check("post_rst_edge4_up", up, 0);
    tick(1'b1, 8'h20);
    check("post_rst_edge5_up", up, 1);
    repeat (10) tick(1'b1, 8'h20);
    chk_cnt("post_rst");

    // Randomised segments of kval / en.
    cyc = 0;
    while (cyc < 20000) begin
      case ($urandom_range(0, 7))
        0:       k = '0;
        1:       k = 8'h80;
        2, 3:    k = KW'($urandom_range(1, 127));
        4, 5:    k = KW'(256 - $urandom_range(1, 127));
        6:       k = KW'($urandom_range(1, 15));
        default: k = KW'(256 - $urandom_range(1, 15));
      endcase
      e = ($urandom_range(0, 9) != 0);
      hold = $urandom_range(1, 30);
      for (int j = 0; j < hold; j++) begin
        tick(e, k);
        cyc++;
      end
      if ($urandom_range(0, 7) == 0) chk_cnt("rand");
    end

    repeat (40) tick(1'b1, 8'h00);
    chk_cnt("final");
    check("final_busy", busy, 0);
    check("final_unseen_pulses", exp_q.size(), 0);
    check("final_cnt_vs_observed", int'(up_cnt) + int'(down_cnt), obs_pulses);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
